// File: rtl/lsu_mem_ctrl.sv
// Handshaked load/store data-memory controller with byte enables, sub-word sign/zero
// extension and optional splitting of word-crossing accesses into two word accesses.
module lsu_mem_ctrl #(
   parameter int unsigned DEPTH            = 1024,
   parameter bit          SPLIT_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [33:0] ByteLimit = 34'(DEPTH) << 2;

   typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] w0_q, w0_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    funct3_q, funct3_d;
   logic          write_q, write_d;
   logic [31:0]   word0_q, word0_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] mem_idx;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic [31:0]   rd_word;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_of = 3'd1;
         2'b01:   size_of = 3'd2;
         default: size_of = 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] assemble(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [63:0] s;
      s = pair >> {off, 3'b000};
      case (f3)
         3'b000:  assemble = {{24{s[7]}}, s[7:0]};
         3'b001:  assemble = {{16{s[15]}}, s[15:0]};
         3'b100:  assemble = {24'b0, s[7:0]};
         3'b101:  assemble = {16'b0, s[15:0]};
         default: assemble = s[31:0];
      endcase
   endfunction

   // Acceptance-time checks on the incoming request
   logic [2:0] req_size;
   logic       req_legal, req_mis, req_oor, req_fault;

   always_comb begin
      req_size  = size_of(req_funct3);
      req_legal = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      req_mis   = (req_addr[1:0] & 2'(req_size - 3'd1)) != 2'b00;
      req_oor   = ({2'b00, req_addr} + {31'b0, req_size} - 34'd1) >= ByteLimit;
      req_fault = !req_legal || (req_mis && !SPLIT_MISALIGNED) || req_oor;
   end

   // Latched-request derived byte mask and 64-bit store lane
   logic [2:0]  cur_size;
   logic [3:0]  size_mask;
   logic [7:0]  mask8;
   logic [63:0] lane;
   logic        crossing;

   always_comb begin
      cur_size = size_of(funct3_q);
      case (cur_size)
         3'd1:    size_mask = 4'b0001;
         3'd2:    size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
      mask8    = {4'b0000, size_mask} << off_q;
      lane     = {32'b0, wdata_q} << {off_q, 3'b000};
      crossing = ({2'b00, off_q} + {1'b0, cur_size}) > 4'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         w0_q     <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         word0_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         w0_q     <= w0_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         write_q  <= write_d;
         word0_q  <= word0_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign rd_word = mem_q[mem_idx];

   always_comb begin
      state_d  = state_q;
      w0_d     = w0_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      write_d  = write_q;
      word0_d  = word0_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               w0_d     = req_addr[AW+1:2];
               off_d    = req_addr[1:0];
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               write_d  = req_write;
               fault_d  = req_fault;
               rdata_d  = '0;
               state_d  = req_fault ? StResp : StAcc0;
            end
         end
         StAcc0: begin
            word0_d = rd_word;
            if (crossing) begin
               state_d = StAcc1;
            end else begin
               rdata_d = write_q ? 32'b0 : assemble({32'b0, rd_word}, off_q, funct3_q);
               state_d = StResp;
            end
         end
         StAcc1: begin
            rdata_d = write_q ? 32'b0 : assemble({rd_word, word0_q}, off_q, funct3_q);
            state_d = StResp;
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      resp_valid = (state_q == StResp);
      mem_idx    = w0_q;
      mem_be     = 4'b0000;
      mem_wdata  = lane[31:0];
      if (state_q == StAcc0) begin
         mem_be = write_q ? mask8[3:0] : 4'b0000;
      end else if (state_q == StAcc1) begin
         mem_idx   = w0_q + AW'(1);
         mem_be    = write_q ? mask8[7:4] : 4'b0000;
         mem_wdata = lane[63:32];
      end
   end

   // Reset has priority so a store interrupted in the second word leaves it untouched
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: instance a splits misaligned accesses, instance b faults them.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_ready;

   logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_fault;
   logic [31:0] a_resp_rdata;
   logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_fault;
   logic [31:0] b_resp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.DEPTH(1024), .SPLIT_MISALIGNED(1'b1)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (a_req_valid),
      .req_ready  (a_req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .resp_valid (a_resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (a_resp_rdata),
      .resp_fault (a_resp_fault)
   );

   lsu_mem_ctrl #(.DEPTH(1024), .SPLIT_MISALIGNED(1'b0)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (b_req_valid),
      .req_ready  (b_req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .resp_valid (b_resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (b_resp_rdata),
      .resp_fault (b_resp_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full request/response transaction on instance a (sel=0) or b (sel=1)
   task automatic xact(input bit sel, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_f,
                       input int exp_lat, input string tag);
      int lat;
      @(negedge clk);
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      if (sel) b_req_valid = 1'b1;
      else     a_req_valid = 1'b1;
      chk({tag, ".ready"}, 32'(sel ? b_req_ready : a_req_ready), 32'd1);
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      lat = 1;
      while (!(sel ? b_resp_valid : a_resp_valid) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"},   32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, sel ? b_resp_rdata : a_resp_rdata, exp_rd);
      chk({tag, ".fault"}, 32'(sel ? b_resp_fault : a_resp_fault), 32'(exp_f));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, ".drop"}, 32'(sel ? b_resp_valid : a_resp_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_funct3 = '0;
      resp_ready = 1'b0;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst.ready", 32'(a_req_ready), 32'd1);
      chk("rst.valid", 32'(a_resp_valid), 32'd0);
      chk("rst.rdata", a_resp_rdata, 32'd0);
      chk("rst.fault", 32'(a_resp_fault), 32'd0);
      chk("rst.b_valid", 32'(b_resp_valid), 32'd0);

      // Word store/load
      xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, "sw10");
      xact(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, "lw10");

      // Byte store into a word, sub-word loads
      xact(0, 1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, 2, "sw10b");
      xact(0, 1, 3'b000, 32'h11, 32'h000000AB, 32'h0, 0, 2, "sb11");
      xact(0, 0, 3'b010, 32'h10, 32'h0, 32'h1122AB44, 0, 2, "lw10b");
      xact(0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAB, 0, 2, "lb11");
      xact(0, 0, 3'b100, 32'h11, 32'h0, 32'h000000AB, 0, 2, "lbu11");
      xact(0, 0, 3'b001, 32'h10, 32'h0, 32'hFFFFAB44, 0, 2, "lh10");
      xact(0, 0, 3'b101, 32'h12, 32'h0, 32'h00001122, 0, 2, "lhu12");

      // Backpressure: response held for 5 cycles
      @(negedge clk);
      req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; a_req_valid = 1'b1;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp.valid", 32'(a_resp_valid), 32'd1);
         chk("bp.rdata", a_resp_rdata, 32'h1122AB44);
         chk("bp.ready", 32'(a_req_ready), 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("bp.drop", 32'(a_resp_valid), 32'd0);

      // Word-crossing accesses split into two words
      xact(0, 1, 3'b010, 32'h10, 32'h0, 32'h0, 0, 2, "z10");
      xact(0, 1, 3'b010, 32'h14, 32'h0, 32'h0, 0, 2, "z14");
      xact(0, 1, 3'b010, 32'h13, 32'hCAFEBABE, 32'h0, 0, 3, "sw13");
      xact(0, 0, 3'b010, 32'h10, 32'h0, 32'hBE000000, 0, 2, "lw10c");
      xact(0, 0, 3'b010, 32'h14, 32'h0, 32'h00CAFEBA, 0, 2, "lw14c");
      xact(0, 0, 3'b010, 32'h13, 32'h0, 32'hCAFEBABE, 0, 3, "lw13");
      xact(0, 0, 3'b001, 32'h13, 32'h0, 32'hFFFFBABE, 0, 3, "lh13");
      xact(0, 0, 3'b101, 32'h13, 32'h0, 32'h0000BABE, 0, 3, "lhu13");
      xact(0, 0, 3'b010, 32'h12, 32'h0, 32'hFEBABE00, 0, 3, "lw12");

      // Non-splitting instance faults misaligned accesses
      xact(1, 1, 3'b010, 32'h00, 32'h55667788, 32'h0, 0, 2, "b.sw0");
      xact(1, 0, 3'b001, 32'h01, 32'h0, 32'h0, 1, 1, "b.lh1");
      xact(1, 1, 3'b001, 32'h03, 32'h0000FFFF, 32'h0, 1, 1, "b.sh3");
      xact(1, 0, 3'b010, 32'h00, 32'h0, 32'h55667788, 0, 2, "b.lw0");
      xact(1, 0, 3'b000, 32'h01, 32'h0, 32'h00000077, 0, 2, "b.lb1");
      xact(1, 0, 3'b010, 32'h02, 32'h0, 32'h0, 1, 1, "b.lw2");

      // Bounds and illegal funct3
      xact(0, 1, 3'b010, 32'hFFC, 32'h01020304, 32'h0, 0, 2, "swFFC");
      xact(0, 0, 3'b010, 32'hFFC, 32'h0, 32'h01020304, 0, 2, "lwFFC");
      xact(0, 0, 3'b001, 32'hFFE, 32'h0, 32'h00000102, 0, 2, "lhFFE");
      xact(0, 0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1, 1, "lwFFE");
      xact(0, 0, 3'b000, 32'h1000, 32'h0, 32'h0, 1, 1, "lb1000");
      xact(0, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1, "lwtop");
      xact(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, "f3_011");
      xact(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 1, "st_f3_100");
      xact(0, 0, 3'b010, 32'h10, 32'h0, 32'hBE000000, 0, 2, "lw10d");

      // Reset during the second word of a split store
      xact(0, 1, 3'b010, 32'h20, 32'h11111111, 32'h0, 0, 2, "sw20");
      xact(0, 1, 3'b010, 32'h24, 32'h22222222, 32'h0, 0, 2, "sw24");
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h22; req_wdata = 32'hAABBCCDD; req_funct3 = 3'b010;
      a_req_valid = 1'b1;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstacc1.valid", 32'(a_resp_valid), 32'd0);
      chk("rstacc1.ready", 32'(a_req_ready), 32'd1);
      xact(0, 0, 3'b010, 32'h20, 32'h0, 32'hCCDD1111, 0, 2, "lw20");
      xact(0, 0, 3'b010, 32'h24, 32'h0, 32'h22222222, 0, 2, "lw24");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised, handshaked load/store data-memory controller. It succeeds the combinational sub-word data-memory wrapper.
- Holds a byte-enabled word array and supports LB/LH/LW/LBU/LHU/SB/SH/SW.
- Splits misaligned accesses into two word accesses, or faults them when splitting is disabled.
- Flags illegal funct3 and out-of-range addresses. Sits between the MEM stage and the data array.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >= 2
SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = fault any misaligned access

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller accepts request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; low bytes used for SB/SH
req_funct3  input  3  RISC-V funct3 size/sign code
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  load result, extended; 0 for stores and faults
resp_fault  output  1  1 = misaligned-disallowed, out-of-range or illegal funct3

Behaviour:
- Reset: synchronous, active-high.
  - Effect: state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0.
  - Memory contents are not cleared.
  - Reset during ACC1 abandons the second word. A split store keeps its already-written first word.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1; req_ready=0 in all other states. On req_valid, latch addr/wdata/funct3/write, size S (1/2/4), offset o=addr[1:0] and w0=addr>>2.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Fault check, done at acceptance, in priority order:
  - illegal funct3;
  - misaligned (addr mod S != 0) with SPLIT_MISALIGNED=0;
  - addr+S-1 >= 4*DEPTH.
- Faulting request: goes IDLE->RESP with resp_fault=1, resp_rdata=0. No memory write.
- Non-faulting request: goes IDLE->ACC0.
- ACC0: access word w0.
  - Store: write lanes where the byte-enable (mask of S bytes << o) is set; lanes [3:0]. Other bytes are untouched; there is no read-modify-write.
  - Load: registered read of w0.
  - Next state: ACC1 if o+S>4, else RESP.
- ACC1: access w0+1. Store enables are mask bits [7:4]; data is the upper half of (wdata<<8o) in a 64-bit lane. Next state RESP.
- Load assembly in RESP entry: bytes = {w1,w0} >> 8o (w1=0 if unused), then truncate to S and extend:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: none.
- RESP: resp_valid=1, outputs stable until resp_ready. On resp_ready, go to IDLE and drop resp_valid. The next request can be accepted the following cycle; there is no same-cycle turnaround.
- Latency, counted from the acceptance edge to resp_valid high:
  - aligned or non-crossing: 2 cycles;
  - crossing: 3 cycles;
  - fault: 1 cycle.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Addresses above 4*DEPTH never wrap; they fault.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, fault=0, 2-cycle latency each.
- SB 0xAB @0x11 over 0x11223344 -> LW @0x10 returns 0x1122AB44. Then LB @0x11 -> 0xFFFFFFAB; LBU -> 0x000000AB.
- SPLIT_MISALIGNED=1: SW 0xCAFEBABE @0x13 (words 0x10 and 0x14 pre-zeroed) -> word@0x10=0xBE000000, word@0x14=0x00CAFEBA. LW @0x13 returns 0xCAFEBABE with 3-cycle latency. LH @0x13 -> 0xFFFFBABE.
- SPLIT_MISALIGNED=0: LH @0x01 -> resp_fault=1, rdata=0, 1-cycle latency. SH @0x03 -> fault, memory unchanged.
- Bounds, DEPTH=1024: LW @0xFFC -> ok. LW @0xFFE -> fault. LB @0x1000 -> fault. funct3=011 load -> fault.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0. Assert rst during ACC1 of a split SW -> IDLE next cycle, resp_valid=0, first word written, second word unchanged.
